prf_multiport: RTL and testbench

Parametrised physical register file for the out-of-order core, replacing the fixed 2-read/1-write PRF. Holds a data word and a ready (valid) bit per physical register. Serves N dispatch read ports, M CDB writeback ports, K commit read ports and K retire-invalidate ports. Supports a masked branch-miss flush that preserves committed mappings, and exports a registered count of ready entries for dispatch throttling.

---
 rtl/prf_multiport.sv | 186 ++++++++++++++++++
 tb/tb_prf_multiport.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_multiport.sv
// prf_multiport
// -------------
// Parametrised physical register file for the out-of-order core. Each physical
// register (preg) holds a data word and a ready bit. Preg 0 is hardwired to
// ready=1 / data=0 and ignores every write, retire and flush.
//
// Optional feature macro: PRF_WB_BYPASS_EN
//   defined   - dispatch and commit reads forward same-cycle CDB writeback data
//   undefined - reads return registered state only
//
// Parameters:
//   NUM_PREGS   number of physical registers (power of two, >= 8)
//   DATA_WIDTH  width of each register
//   NUM_RD      dispatch read ports
//   NUM_WB      CDB writeback ports
//   NUM_CM      commit read ports and retire-invalidate ports
//   PA_W        physical address width (derived)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   branch_miss  flush strobe; clears ready bits not protected by flush_keep
//   flush_keep   per-preg mask, bit set = ready bit survives a flush
//   rd_paddr     dispatch read addresses        -> rd_valid / rd_data
//   wb_en/wb_paddr/wb_data  CDB writebacks (highest port index wins on collision)
//   cm_paddr     commit read addresses          -> cm_data
//   ret_en/ret_paddr        retire invalidates (clear ready bit only)
//   ready_count  registered popcount of the ready array
//   wb_conflict  registered flag: two enabled wb ports hit the same preg

module prf_multiport #(
    parameter  int NUM_PREGS  = 64,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_RD     = 4,
    parameter  int NUM_WB     = 2,
    parameter  int NUM_CM     = 2,
    localparam int PA_W       = $clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         branch_miss,
    input  logic [NUM_PREGS-1:0]         flush_keep,
    input  logic [NUM_RD*PA_W-1:0]       rd_paddr,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_WB-1:0]            wb_en,
    input  logic [NUM_WB*PA_W-1:0]       wb_paddr,
    input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
    input  logic [NUM_CM*PA_W-1:0]       cm_paddr,
    output logic [NUM_CM*DATA_WIDTH-1:0] cm_data,
    input  logic [NUM_CM-1:0]            ret_en,
    input  logic [NUM_CM*PA_W-1:0]       ret_paddr,
    output logic [PA_W:0]                ready_count,
    output logic                         wb_conflict
);

    logic [NUM_PREGS-1:0]  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q [NUM_PREGS];
    logic [DATA_WIDTH-1:0] data_d [NUM_PREGS];
    logic [PA_W:0]         readyCount_q, readyCount_d;
    logic                  wbConflict_q, wbConflict_d;

    logic [PA_W-1:0]       rdAddr;
    logic [PA_W-1:0]       cmAddr;

    // Next-state for the array. Later assignments override earlier ones, so
    // the statements are ordered from lowest to highest priority:
    // hold -> retire -> writeback -> flush -> reset, with preg 0 forced last.
    // Data is written by writebacks regardless of a same-cycle flush; only
    // the ready bit is subject to the flush.
    always_comb begin
        ready_d = ready_q;
        data_d  = data_q;

        for (int j = 0; j < NUM_CM; j++) begin
            if (ret_en[j]) begin
                ready_d[ret_paddr[j*PA_W +: PA_W]] = 1'b0;
            end
        end

        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i]) begin
                ready_d[wb_paddr[i*PA_W +: PA_W]] = 1'b1;
                data_d[wb_paddr[i*PA_W +: PA_W]]  = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (branch_miss) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                if (!flush_keep[p]) begin
                    ready_d[p] = 1'b0;
                end
            end
        end

        if (rst) begin
            ready_d = '0;
            for (int p = 0; p < NUM_PREGS; p++) begin
                data_d[p] = '0;
            end
        end

        ready_d[0] = 1'b1;
        data_d[0]  = '0;
    end

    // A writeback collision is any pair of enabled ports sharing an address.
    // The count is taken from the next-state array so that, once registered,
    // it agrees with the array contents visible in the same cycle.
    always_comb begin
        wbConflict_d = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            for (int k = i + 1; k < NUM_WB; k++) begin
                if (wb_en[i] && wb_en[k] &&
                    (wb_paddr[i*PA_W +: PA_W] == wb_paddr[k*PA_W +: PA_W])) begin
                    wbConflict_d = 1'b1;
                end
            end
        end
        if (rst) begin
            wbConflict_d = 1'b0;
        end

        readyCount_d = '0;
        for (int p = 0; p < NUM_PREGS; p++) begin
            readyCount_d = readyCount_d + {{PA_W{1'b0}}, ready_d[p]};
        end
    end

    // State registers. Reset is folded into the next-state logic above so
    // that it overrides every same-cycle write, retire and flush.
    always_ff @(posedge clk) begin
        ready_q      <= ready_d;
        data_q       <= data_d;
        readyCount_q <= readyCount_d;
        wbConflict_q <= wbConflict_d;
    end

    // Dispatch reads. With bypass enabled a matching writeback forwards its
    // data (highest port wins because of loop order); the valid bit still
    // honours a same-cycle flush of that preg. Preg 0 never bypasses.
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        rdAddr   = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rdAddr = rd_paddr[r*PA_W +: PA_W];
            rd_valid[r] = ready_q[rdAddr];
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[rdAddr];
`ifdef PRF_WB_BYPASS_EN
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (rdAddr != '0) &&
                    (wb_paddr[i*PA_W +: PA_W] == rdAddr)) begin
                    rd_valid[r] = !(branch_miss && !flush_keep[rdAddr]);
                    rd_data[r*DATA_WIDTH +: DATA_WIDTH] = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`else
`endif
        end
    end

    // Commit reads feed the architectural register file; they forward data
    // only, there is no valid bit on these ports.
    always_comb begin
        cm_data = '0;
        cmAddr  = '0;
        for (int c = 0; c < NUM_CM; c++) begin
            cmAddr = cm_paddr[c*PA_W +: PA_W];
            cm_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q[cmAddr];
`ifdef PRF_WB_BYPASS_EN
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (cmAddr != '0) &&
                    (wb_paddr[i*PA_W +: PA_W] == cmAddr)) begin
                    cm_data[c*DATA_WIDTH +: DATA_WIDTH] = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`else
`endif
        end
    end

    assign ready_count = readyCount_q;
    assign wb_conflict = wbConflict_q;

endmodule

// File: tb/tb_prf_multiport.sv
// tb_prf_multiport
// ----------------
// Directed bench for prf_multiport. Stimulus tasks drive one cycle of inputs
// and push the expected outputs (tagged with the cycle they belong to) into a
// scoreboard queue; an independent monitor pops and compares on the falling
// edge. Expectations that depend on write bypass follow PRF_WB_BYPASS_EN.

module tb_prf_multiport;

    localparam int NUM_PREGS  = 64;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_RD     = 4;
    localparam int NUM_WB     = 2;
    localparam int NUM_CM     = 2;
    localparam int PA_W       = 6;

    localparam int K_RDVALID = 0;
    localparam int K_RDDATA  = 1;
    localparam int K_CMDATA  = 2;
    localparam int K_COUNT   = 3;
    localparam int K_CONFL   = 4;

    logic                         clk;
    logic                         rst;
    logic                         branchMiss;
    logic [NUM_PREGS-1:0]         flushKeep;
    logic [NUM_RD*PA_W-1:0]       rdPaddr;
    logic [NUM_RD-1:0]            rdValid;
    logic [NUM_RD*DATA_WIDTH-1:0] rdData;
    logic [NUM_WB-1:0]            wbEn;
    logic [NUM_WB*PA_W-1:0]       wbPaddr;
    logic [NUM_WB*DATA_WIDTH-1:0] wbData;
    logic [NUM_CM*PA_W-1:0]       cmPaddr;
    logic [NUM_CM*DATA_WIDTH-1:0] cmData;
    logic [NUM_CM-1:0]            retEn;
    logic [NUM_CM*PA_W-1:0]       retPaddr;
    logic [PA_W:0]                readyCount;
    logic                         wbConflict;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } chk_t;

    chk_t sbQ[$];
    int   cycleCnt    = 0;
    int   nCompared   = 0;
    int   nMismatched = 0;

    prf_multiport #(
        .NUM_PREGS (NUM_PREGS),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_RD    (NUM_RD),
        .NUM_WB    (NUM_WB),
        .NUM_CM    (NUM_CM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .branch_miss(branchMiss),
        .flush_keep (flushKeep),
        .rd_paddr   (rdPaddr),
        .rd_valid   (rdValid),
        .rd_data    (rdData),
        .wb_en      (wbEn),
        .wb_paddr   (wbPaddr),
        .wb_data    (wbData),
        .cm_paddr   (cmPaddr),
        .cm_data    (cmData),
        .ret_en     (retEn),
        .ret_paddr  (retPaddr),
        .ready_count(readyCount),
        .wb_conflict(wbConflict)
    );

    // Free-running clock and a cycle index used to tag expectations.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Compare one scoreboard entry against whatever the DUT shows now. An
    // entry whose cycle has already passed is itself an error.
    task automatic checkOutput(input chk_t c);
        logic [31:0] act;
        case (c.kind)
            K_RDVALID: act = {31'd0, rdValid[c.port]};
            K_RDDATA:  act = rdData[c.port*DATA_WIDTH +: DATA_WIDTH];
            K_CMDATA:  act = cmData[c.port*DATA_WIDTH +: DATA_WIDTH];
            K_COUNT:   act = {25'd0, readyCount};
            default:   act = {31'd0, wbConflict};
        endcase
        nCompared++;
        if (act !== c.exp || c.cyc != cycleCnt) begin
            nMismatched++;
            $display("[TB] FAIL %s (cycle %0d, due %0d): got 0x%0h, expected 0x%0h",
                     c.name, cycleCnt, c.cyc, act, c.exp);
        end
    endtask

    // Monitor: checks every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cycleCnt) begin
            checkOutput(sbQ.pop_front());
        end
    end

    // Queue an expectation for this cycle (ahead=0) or the next (ahead=1).
    task automatic expectOut(input string name, input int kind, input int port,
                             input logic [31:0] exp, input int ahead);
        chk_t c;
        c.cyc  = cycleCnt + ahead;
        c.name = name;
        c.kind = kind;
        c.port = port;
        c.exp  = exp;
        sbQ.push_back(c);
    endtask

    // Advance to the next cycle and return all inputs to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        branchMiss = 1'b0;
        flushKeep  = '0;
        rdPaddr    = '0;
        wbEn       = '0;
        wbPaddr    = '0;
        wbData     = '0;
        cmPaddr    = '0;
        retEn      = '0;
        retPaddr   = '0;
    endtask

    task automatic setRd(input int p, input int addr);
        rdPaddr[p*PA_W +: PA_W] = addr[PA_W-1:0];
    endtask

    task automatic setCm(input int p, input int addr);
        cmPaddr[p*PA_W +: PA_W] = addr[PA_W-1:0];
    endtask

    task automatic setWb(input int p, input int addr, input logic [31:0] d);
        wbEn[p] = 1'b1;
        wbPaddr[p*PA_W +: PA_W] = addr[PA_W-1:0];
        wbData[p*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic setRet(input int p, input int addr);
        retEn[p] = 1'b1;
        retPaddr[p*PA_W +: PA_W] = addr[PA_W-1:0];
    endtask

    task automatic expectRd(input string name, input int p, input logic v,
                            input logic [31:0] d, input int ahead);
        expectOut({name, "_valid"}, K_RDVALID, p, {31'd0, v}, ahead);
        expectOut({name, "_data"},  K_RDDATA,  p, d, ahead);
    endtask

    initial begin
        rst = 1'b1;
        branchMiss = 1'b0;
        flushKeep = '0;
        rdPaddr = '0;
        wbEn = '0;
        wbPaddr = '0;
        wbData = '0;
        cmPaddr = '0;
        retEn = '0;
        retPaddr = '0;
        repeat (2) @(posedge clk);

        // Post-reset: addr 5 not ready and zero, addr 0 hardwired ready.
        applyStimulus();
        setRd(0, 5); setRd(1, 0); setRd(2, 5); setRd(3, 5); setCm(0, 5);
        expectRd("rst_rd0_a5", 0, 1'b0, 32'h0, 0);
        expectRd("rst_rd1_a0", 1, 1'b1, 32'h0, 0);
        expectRd("rst_rd3_a5", 3, 1'b0, 32'h0, 0);
        expectOut("rst_cm0", K_CMDATA, 0, 32'h0, 0);
        expectOut("rst_count", K_COUNT, 0, 32'd1, 0);
        expectOut("rst_conflict", K_CONFL, 0, 32'd0, 0);

        // Writeback to preg 7 read on the same cycle.
        applyStimulus();
        setWb(0, 7, 32'hDEADBEEF); setRd(2, 7); setCm(0, 7);
`ifdef PRF_WB_BYPASS_EN
        expectRd("wb7_same_rd2", 2, 1'b1, 32'hDEADBEEF, 0);
        expectOut("wb7_same_cm0", K_CMDATA, 0, 32'hDEADBEEF, 0);
`else
        expectRd("wb7_same_rd2", 2, 1'b0, 32'h0, 0);
        expectOut("wb7_same_cm0", K_CMDATA, 0, 32'h0, 0);
`endif

        // Preg 7 visible; colliding writes to preg 9 issued.
        applyStimulus();
        setRd(2, 7); setCm(0, 7); setRd(0, 9);
        setWb(0, 9, 32'h11); setWb(1, 9, 32'h22);
        expectRd("wb7_next_rd2", 2, 1'b1, 32'hDEADBEEF, 0);
        expectOut("wb7_next_cm0", K_CMDATA, 0, 32'hDEADBEEF, 0);
        expectOut("wb7_count", K_COUNT, 0, 32'd2, 0);
        expectOut("wb7_conflict", K_CONFL, 0, 32'd0, 0);
`ifdef PRF_WB_BYPASS_EN
        expectRd("wb9_same_rd0", 0, 1'b1, 32'h22, 0);
`else
        expectRd("wb9_same_rd0", 0, 1'b0, 32'h0, 0);
`endif

        // Highest port wins on preg 9; write pregs 3 and 4.
        applyStimulus();
        setRd(0, 9);
        setWb(0, 3, 32'h33); setWb(1, 4, 32'h44);
        expectRd("wb9_next_rd0", 0, 1'b1, 32'h22, 0);
        expectOut("wb9_conflict", K_CONFL, 0, 32'd1, 0);
        expectOut("wb9_count", K_COUNT, 0, 32'd3, 0);

        // Write preg 5 and retire 7 and 9 so only 0,3,4,5 stay ready.
        applyStimulus();
        setWb(0, 5, 32'h55); setRet(0, 7); setRet(1, 9);
        expectOut("wb34_conflict", K_CONFL, 0, 32'd0, 0);
        expectOut("wb34_count", K_COUNT, 0, 32'd5, 0);

        // Flush keeping only preg 4.
        applyStimulus();
        setRd(0, 3); setRd(1, 4); setRd(2, 5); setRd(3, 7);
        branchMiss = 1'b1;
        flushKeep[4] = 1'b1;
        expectRd("pre_flush_rd3", 0, 1'b1, 32'h33, 0);
        expectRd("pre_flush_rd5", 2, 1'b1, 32'h55, 0);
        expectRd("retired_rd7", 3, 1'b0, 32'hDEADBEEF, 0);
        expectOut("pre_flush_count", K_COUNT, 0, 32'd4, 0);

        // After flush: 3 and 5 cleared, 4 kept, data untouched.
        applyStimulus();
        setRd(0, 3); setRd(1, 4); setRd(2, 5); setRd(3, 0);
        setWb(0, 12, 32'hAAAA); setRet(0, 12);
        expectRd("flush_rd3", 0, 1'b0, 32'h33, 0);
        expectRd("flush_rd4", 1, 1'b1, 32'h44, 0);
        expectRd("flush_rd5", 2, 1'b0, 32'h55, 0);
        expectRd("flush_rd0", 3, 1'b1, 32'h0, 0);
        expectOut("flush_count", K_COUNT, 0, 32'd2, 0);

        // Writeback beats retire on preg 12; then write it under a flush.
        applyStimulus();
        setRd(0, 12); setRd(1, 12);
        setWb(1, 12, 32'hBBBB);
        branchMiss = 1'b1;
        flushKeep[4] = 1'b1;
        expectRd("wb_vs_ret_rd12", 0, 1'b1, 32'hAAAA, 0);
        expectOut("wb_vs_ret_count", K_COUNT, 0, 32'd3, 0);
`ifdef PRF_WB_BYPASS_EN
        expectRd("wb_flush_same_rd12", 1, 1'b0, 32'hBBBB, 0);
`else
        expectRd("wb_flush_same_rd12", 1, 1'b1, 32'hAAAA, 0);
`endif

        // Flush wins the ready bit, writeback still lands the data.
        applyStimulus();
        setRd(0, 12); setCm(1, 12);
        expectRd("wb_flush_rd12", 0, 1'b0, 32'hBBBB, 0);
        expectOut("wb_flush_cm12", K_CMDATA, 1, 32'hBBBB, 0);
        expectOut("wb_flush_count", K_COUNT, 0, 32'd2, 0);

        // Reset together with colliding writes to preg 8.
        applyStimulus();
        rst = 1'b1;
        setWb(0, 8, 32'h88); setWb(1, 8, 32'h99);

        applyStimulus();
        setRd(0, 8); setRd(1, 4); setRd(2, 9);
        setWb(0, 0, 32'hFFFF); setRet(0, 0);
        expectRd("rst_wb_rd8", 0, 1'b0, 32'h0, 0);
        expectRd("rst_wb_rd4", 1, 1'b0, 32'h0, 0);
        expectRd("rst_wb_rd9", 2, 1'b0, 32'h0, 0);
        expectOut("rst_wb_count", K_COUNT, 0, 32'd1, 0);
        expectOut("rst_wb_conflict", K_CONFL, 0, 32'd0, 0);

        // Preg 0 ignores writes and retires.
        applyStimulus();
        setRd(0, 0);
        expectRd("preg0_rd", 0, 1'b1, 32'h0, 0);
        expectOut("preg0_count", K_COUNT, 0, 32'd1, 0);

        // Let the monitor drain; anything left over was never checked.
        repeat (3) @(posedge clk);
        while (sbQ.size() > 0) begin
            chk_t c;
            c = sbQ.pop_front();
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: never checked, expected 0x%0h", c.name, c.exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
